spi_master_ctrl: RTL and testbench
==================================

// Module: spi_master_ctrl
// PURPOSE
//   Upstream SPI master for the spi slave + RAM subsystem. Accepts RAM commands
//   on a valid/ready interface, serialises each into one ss_n-framed transfer on
//   mosi (one bit per clk), and for read-data commands captures the 8-bit reply
//   from miso and returns it on a one-cycle response strobe. Its mosi, ss_n and
//   miso connect directly to the matching ports of the spi top level.
// PARAMETERS
//   RD_WAIT   2  ss_n-low turnaround cycles between last mosi bit and first miso sample (>=1)
//   IDLE_GAP  1  minimum ss_n-high cycles after every frame (>=1)
// PORTS
//   clk        in   1  system clock; also the SPI bit clock
//   rst        in   1  synchronous reset, active-high
//   cmd_valid  in   1  command request
//   cmd_ready  out  1  high in IDLE only; command accepted when cmd_valid && cmd_ready
//   cmd_op     in   2  00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data   in   8  address/data payload (ignored for 11, sent as 0x00)
//   rsp_valid  out  1  one-cycle pulse: rsp_data holds read byte
//   rsp_data   out  8  last byte read; held until next read completes
//   busy       out  1  high whenever state != IDLE
//   ss_n       out  1  slave select, active-low, registered
//   mosi       out  1  serial data to slave, registered
//   miso       in   1  serial data from slave
// BEHAVIOUR
//   - Reset (rst=1 at edge): state IDLE, ss_n=1, mosi=0, rsp_valid=0, rsp_data=0x00,
//     counters 0; cmd_ready=1/busy=0 from first cycle after reset.
//   - Command latched into shadow reg on acceptance (edge T); inputs ignored while busy.
//   - Frame word F[9:0] = {cmd_op, cmd_data} (cmd_data forced 0x00 for op 11).
//   - FSM states / timing (edge T = accept):
//     IDLE -> SEL on accept. SEL, cycle after T: ss_n=0, mosi=cmd_op[1] (rd/wr select).
//     SEL -> SHIFT: 10 cycles, mosi=F[9]..F[0] MSB first, ss_n=0.
//     SHIFT -> GAP if op!=11; -> WAIT if op==11.
//     WAIT: RD_WAIT cycles, ss_n=0, mosi=0.
//     RECV: 8 cycles, ss_n=0, mosi=0; miso sampled each edge, shifted in MSB first.
//     GAP: IDLE_GAP cycles, ss_n=1, mosi=0; on entry from RECV rsp_data<=captured
//       byte and rsp_valid=1 for exactly the first GAP cycle. GAP -> IDLE.
//   - Write/rd-addr frame: ss_n low 11 cycles; next accept earliest edge T+12+IDLE_GAP.
//   - Rd-data frame: ss_n low 11+RD_WAIT+8 cycles, never deasserted mid-frame.
//   - ss_n and mosi change only on clk edges; no glitches (registered outputs).
//   - Bit counter 4 bits, shared by SHIFT/WAIT/RECV, cleared on every state change.
//   - Reset mid-frame: next edge ss_n=1, mosi=0, state IDLE, frame abandoned,
//     no rsp_valid, rsp_data cleared to 0x00.
//   - cmd_valid asserted in same cycle GAP->IDLE transition occurs is not accepted
//     until cmd_ready is visibly high (ready depends on registered state only).
// TESTING
//   1 Reset: hold rst 3 cycles mid-idle -> ss_n=1, mosi=0, rsp_valid=0, cmd_ready=1 after.
//   2 Wr-addr op=00 data=0x3C -> ss_n low 11 cycles, mosi 0,0,0,0,0,1,1,1,1,0,0; no rsp_valid.
//   3 Rd-data op=11, slave model drives 0xA5 after RD_WAIT -> mosi 1,1,1 then zeros,
//     rsp_valid pulses once with rsp_data=0xA5, ss_n low 21 cycles (RD_WAIT=2).
//   4 Full sequence through spi top: 00/0x10, 01/0x5A, 10/0x10, 11 -> rsp_data=0x5A.
//   5 cmd_valid held high continuously with 2 queued ops -> exactly one accept per
//     frame, >=IDLE_GAP ss_n-high cycles between frames, cmd_ready low while busy.
//   6 rst pulsed during RECV bit 4 -> ss_n=1 next edge, no rsp_valid, rsp_data=0x00,
//     next command frames correctly.

Source files
------------

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: serialises valid/ready RAM commands into ss_n-framed SPI transfers and captures read replies
module spi_master_ctrl #(
    parameter int RD_WAIT  = 2,
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       ss_n,
    output logic       mosi,
    input  logic       miso
);
    typedef enum logic [2:0] {IDLE, SEL, SHIFT, WAIT, RECV, GAP} state_t;
    state_t     state, state_d;
    logic [3:0] cnt, cnt_d;
    logic [9:0] frame, frame_d;
    logic [7:0] rx;
    logic       accept, ss_n_d, mosi_d, done;
    assign cmd_ready = state == IDLE;
    assign busy      = state != IDLE;
    assign accept    = cmd_valid && cmd_ready;
    assign done      = state == RECV && cnt == 4'd7;
    // next state, shared bit counter, and the pin values for the state being entered
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 4'd1;
        frame_d = accept ? {cmd_op, cmd_op == 2'b11 ? 8'h00 : cmd_data} : frame;
        case (state)
            IDLE:    if (accept) state_d = SEL;
            SEL:     state_d = SHIFT;
            SHIFT:   if (cnt == 4'd9) state_d = frame[9:8] == 2'b11 ? WAIT : GAP;
            WAIT:    if (cnt == 4'(RD_WAIT - 1)) state_d = RECV;
            RECV:    if (cnt == 4'd7) state_d = GAP;
            GAP:     if (cnt == 4'(IDLE_GAP - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d != state || state == IDLE) cnt_d = 4'd0;
        ss_n_d = state_d == IDLE || state_d == GAP;
        mosi_d = state_d == SEL ? frame_d[9] : state_d == SHIFT ? frame_d[4'd9 - cnt_d] : 1'b0;
    end
    // state, counter and command shadow register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            frame <= 10'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            frame <= frame_d;
        end
    end
    // registered SPI pins so ss_n and mosi only move on clock edges
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_n <= 1'b1;
            mosi <= 1'b0;
        end else begin
            ss_n <= ss_n_d;
            mosi <= mosi_d;
        end
    end
    // shift in the reply MSB first and publish it as the frame enters GAP
    always_ff @(posedge clk) begin
        if (rst) begin
            rx        <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
        end else begin
            if (state == RECV) rx <= {rx[6:0], miso};
            rsp_valid <= done;
            if (done) rsp_data <= {rx[6:0], miso};
        end
    end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized self-checking bench with a command-level slave/RAM model
module tb_spi_master_ctrl;
    localparam int RD_WAIT  = 2;
    localparam int IDLE_GAP = 1;
    logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, miso = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_ready, rsp_valid, busy, ss_n, mosi;
    logic [7:0] rsp_data;
    int         errors = 0, checks = 0;
    logic [7:0] mem [256];
    logic [7:0] waddr = 8'h00, raddr = 8'h00;

    spi_master_ctrl #(.RD_WAIT(RD_WAIT), .IDLE_GAP(IDLE_GAP)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .ss_n(ss_n), .mosi(mosi), .miso(miso)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Drive one command and check every cycle of its frame; returns early at cycle abort_at.
    task automatic do_frame(input logic [1:0] op, input logic [7:0] data, input logic [7:0] reply, input int abort_at);
        logic [9:0] f;
        logic       em;
        int         len, n;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_wait got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = data;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = 8'($urandom);
        f   = {op, op == 2'b11 ? 8'h00 : data};
        len = 11 + (op == 2'b11 ? RD_WAIT + 8 : 0);
        for (int k = 0; k < len + IDLE_GAP; k++) begin
            if (k == abort_at) return;
            em = k == 0 ? f[9] : k <= 10 ? f[10 - k] : 1'b0;
            checks++;
            if (ss_n !== (k >= len)) begin errors++; $display("FAIL ss_n op=%0d k=%0d got=%b exp=%b", op, k, ss_n, k >= len); end
            checks++;
            if (mosi !== em) begin errors++; $display("FAIL mosi op=%0d k=%0d got=%b exp=%b", op, k, mosi, em); end
            checks++;
            if (busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL busy_ready k=%0d got=%b%b exp=10", k, busy, cmd_ready); end
            checks++;
            if (rsp_valid !== (op == 2'b11 && k == len)) begin errors++; $display("FAIL rsp_valid k=%0d got=%b exp=%b", k, rsp_valid, op == 2'b11 && k == len); end
            if (op == 2'b11 && k == len) begin
                checks++;
                if (rsp_data !== reply) begin errors++; $display("FAIL rsp_data got=%h exp=%h", rsp_data, reply); end
            end
            miso = (op == 2'b11 && k >= 11 + RD_WAIT && k < len) ? reply[7 - (k - 11 - RD_WAIT)] : 1'($urandom);
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || cmd_ready !== 1'b1 || ss_n !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL frame_end got busy=%b ready=%b ss_n=%b rsp_valid=%b exp 0110", busy, cmd_ready, ss_n, rsp_valid);
        end
    endtask

    // Command-level RAM slave: wr-addr/wr-data store, rd-addr/rd-data fetch.
    task automatic model_cmd(input logic [1:0] op, input logic [7:0] data);
        logic [7:0] reply;
        reply = 8'h00;
        case (op)
            2'b00: waddr = data;
            2'b01: mem[waddr] = data;
            2'b10: raddr = data;
            default: reply = mem[raddr];
        endcase
        do_frame(op, data, reply, -1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ss_n !== 1'b1 || mosi !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00) begin
            errors++; $display("FAIL reset_outputs got ss_n=%b mosi=%b rsp_valid=%b rsp_data=%h exp 1 0 0 00", ss_n, mosi, rsp_valid, rsp_data);
        end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || ss_n !== 1'b1) begin
            errors++; $display("FAIL reset_ready got ready=%b busy=%b ss_n=%b exp 1 0 1", cmd_ready, busy, ss_n);
        end
    endtask

    task automatic test_wr_addr();
        model_cmd(2'b00, 8'h3C);
    endtask

    task automatic test_rd_data();
        do_frame(2'b11, 8'($urandom), 8'hA5, -1);
    endtask

    task automatic test_sequence();
        model_cmd(2'b00, 8'h10);
        model_cmd(2'b01, 8'h5A);
        model_cmd(2'b10, 8'h10);
        model_cmd(2'b11, 8'h00);
        checks++;
        if (rsp_data !== 8'h5A) begin errors++; $display("FAIL seq_readback got=%h exp=5a", rsp_data); end
        for (int i = 0; i < 12; i++) model_cmd(2'($urandom_range(0, 3)), 8'($urandom));
    endtask

    task automatic test_back_to_back();
        logic [7:0] d0, d1;
        logic       acc, prev_ss;
        int         accepts, frames, hi;
        d0 = 8'($urandom); d1 = 8'($urandom);
        accepts = 0; frames = 0; hi = 0; prev_ss = 1'b1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = d0;
        for (int c = 0; c < 60; c++) begin
            acc = cmd_valid && cmd_ready;
            checks++;
            if (cmd_ready !== !busy) begin errors++; $display("FAIL b2b_ready c=%0d got ready=%b busy=%b", c, cmd_ready, busy); end
            if (!ss_n && prev_ss) begin
                if (frames > 0) begin
                    checks++;
                    if (hi != IDLE_GAP + 1) begin errors++; $display("FAIL b2b_gap got=%0d exp=%0d", hi, IDLE_GAP + 1); end
                end
                frames++;
            end
            hi = ss_n ? hi + 1 : 0;
            prev_ss = ss_n;
            if (acc) accepts++;
            @(posedge clk); @(negedge clk);
            if (acc) begin
                if (accepts == 1) begin cmd_op = 2'b01; cmd_data = d1; end
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        waddr = d0; mem[waddr] = d1;
        checks++;
        if (accepts != 2 || frames != 2) begin errors++; $display("FAIL b2b_count got accepts=%0d frames=%0d exp 2 2", accepts, frames); end
    endtask

    task automatic test_reset_recv();
        do_frame(2'b11, 8'h00, 8'h96, -1);
        do_frame(2'b11, 8'h00, 8'h5F, 11 + RD_WAIT + 4);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ss_n !== 1'b1 || mosi !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 8'h00 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset got ss_n=%b mosi=%b rsp_valid=%b rsp_data=%h ready=%b busy=%b", ss_n, mosi, rsp_valid, rsp_data, cmd_ready, busy);
        end
        for (int c = 0; c < 12; c++) begin
            miso = 1'($urandom);
            @(posedge clk); @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0 || ss_n !== 1'b1) begin errors++; $display("FAIL midreset_quiet c=%0d got rsp_valid=%b ss_n=%b exp 0 1", c, rsp_valid, ss_n); end
        end
        waddr = 8'h00; raddr = 8'h00;
        model_cmd(2'b00, 8'h77);
        model_cmd(2'b01, 8'($urandom));
        model_cmd(2'b10, 8'h77);
        model_cmd(2'b11, 8'h00);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
        test_reset();
        test_wr_addr();
        test_rd_data();
        test_sequence();
        test_back_to_back();
        test_reset_recv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
